// File: rtl/thor2023_ifetch_queue_pkg.sv
// Shared types for the instruction fetch queue.
package thor2023_ifetch_queue_pkg;
  typedef logic [31:0] address_t;

  typedef struct packed {
    address_t    pc;
    logic [39:0] insn;
  } ifq_entry_t;

  localparam int INSN_BYTES = 5;
endpackage

// File: rtl/thor2023_ifq_fifo.sv
// Circular buffer of fetched instructions: FETCH_W writes per cycle, one read, synchronous clear.
module thor2023_ifq_fifo
  import thor2023_ifetch_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      wr_en,
  input  ifq_entry_t [FETCH_W-1:0]  wr_data,
  input  logic                      rd_en,
  output ifq_entry_t                head,
  output logic [AW:0]               cnt
);
  ifq_entry_t [DEPTH-1:0] mem;
  logic [AW-1:0]          rp, wp;
  logic                   pop;

  assign pop  = rd_en & (cnt != '0);
  assign head = mem[rp];

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) begin
        for (int k = 0; k < FETCH_W; k++)
          mem[wp + AW'(k)] <= wr_data[k];
        wp <= wp + AW'(FETCH_W);
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (wr_en ? (AW+1)'(FETCH_W) : '0) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/thor2023_ifetch_queue.sv
// Instruction fetch queue between the I$ port and decode.
// Optional perf counters enabled by defining IFQ_PERF_EN.
module thor2023_ifetch_queue
  import thor2023_ifetch_queue_pkg::*;
#(
  parameter int       LINE_W  = 512,
  parameter int       FETCH_W = 2,
  parameter int       DEPTH   = 8,
  parameter address_t RSTPC   = 32'hFFFD0000
) (
  input  logic              clk,
  input  logic              rst,
  output address_t          ip_o,
  output logic              stall_o,
  input  logic              ihit_i,
  input  address_t          ip_i,
  input  logic [LINE_W-1:0] line_lo_i,
  input  logic [LINE_W-1:0] line_hi_i,
  input  logic              flush_i,
  input  address_t          flush_pc_i,
  output logic              ifq_v_o,
  output logic [39:0]       ifq_insn_o,
  output address_t          ifq_pc_o,
  input  logic              ifq_rd_i,
  output logic [31:0]       perf_hit_o,
  output logic [31:0]       perf_stl_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int OFFW  = $clog2(LINE_W/8);
  localparam int EXT_W = FETCH_W*40;

  logic [AW:0]              cnt;
  logic                     accept;
  logic [OFFW-1:0]          off;
  logic [EXT_W-1:0]         win;
  ifq_entry_t [FETCH_W-1:0] wr_data;
  ifq_entry_t               head;

  assign stall_o = ((AW+1)'(DEPTH) - cnt) < (AW+1)'(FETCH_W);
  assign accept  = ihit_i & (ip_i == ip_o) & ~stall_o & ~flush_i;

  // Window starts at the hit's byte offset; may run into the next line.
  assign off = ip_i[OFFW-1:0];
  assign win = EXT_W'({line_hi_i, line_lo_i} >> {off, 3'b000});

  for (genvar k = 0; k < FETCH_W; k++) begin : g_ext
    assign wr_data[k].insn = win[40*k +: 40];
    assign wr_data[k].pc   = ip_i + 32'(INSN_BYTES*k);
  end

  thor2023_ifq_fifo #(.DEPTH(DEPTH), .FETCH_W(FETCH_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush_i),
    .wr_en   (accept),
    .wr_data (wr_data),
    .rd_en   (ifq_rd_i),
    .head    (head),
    .cnt     (cnt)
  );

  assign ifq_v_o    = cnt != '0;
  assign ifq_insn_o = head.insn;
  assign ifq_pc_o   = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ip_o <= RSTPC;
    else if (flush_i) ip_o <= flush_pc_i;
    else if (accept)  ip_o <= ip_o + 32'(INSN_BYTES*FETCH_W);
  end

`ifdef IFQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_o <= '0;
      perf_stl_o <= '0;
    end else begin
      if (accept)  perf_hit_o <= perf_hit_o + 1'b1;
      if (stall_o) perf_stl_o <= perf_stl_o + 1'b1;
    end
  end
`else
  assign perf_hit_o = 32'd0;
  assign perf_stl_o = 32'd0;
`endif
endmodule
